alu3_arb: RTL
=============

ALU3_ARB -- requirements
Module: alu3_arb

Interface
REQ-001 Parameter FIXED_PRIO, default 0, meaning 0 = round-robin between requesters, 1 = requester 0 always wins.
REQ-002 Parameter NUM_OPS_CHK, default 1, meaning 1 = flag unsupported alu3_op codes on rsp_err, 0 = no check.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 req0_valid / req1_valid  input  1 each  request present (0 = execute-stage MMX uop, 1 = REP/LOOP microsequencer).
REQ-006 req0_ready / req1_ready  output  1 each  request accepted this cycle when valid && ready.
REQ-007 reqN_op  input  5  alu3 opcode; reqN_mm1, reqN_mm2  input  64; reqN_sr2, reqN_ecx  input  32.
REQ-008 alu3_op  output  5; mm1, mm2  output  64; sr2, ecx  output  32: registered operands driven to the shared ALU3.
REQ-009 alu_res3  input  64  combinational ALU3 result for the operands currently driven.
REQ-010 rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1; rsp_data  output  64; rsp_err  output  1.
REQ-011 flush  input  1  discard all in-flight work.

Function
REQ-012 Two-stage pipe: S1 = operand registers (s1_valid, s1_id, driving alu3_op/mm1/mm2/sr2/ecx); S2 = response registers (rsp_*).
REQ-013 adv = !rsp_valid || rsp_ready; S1 moves into S2 when s1_valid && adv, capturing alu_res3 into rsp_data.
REQ-014 S1 can accept = !s1_valid || adv; reqN_ready = accept && grantN, combinational, no dependence on reqN_ready of the other port.
REQ-015 Latency: accept in cycle T -> rsp_valid in T+1 (registered at edge T+1 if adv), rsp_data = alu_res3 of that op.
REQ-016 Throughput: one accept per cycle while rsp_ready = 1; back-to-back responses without bubbles.
REQ-017 Grant, FIXED_PRIO = 0: only one valid -> that one; both valid -> requester != last_grant; last_grant updates only on an accepted transfer.
REQ-018 Grant, FIXED_PRIO = 1: requester 0 whenever req0_valid, else requester 1.
REQ-019 At most one of req0_ready/req1_ready high in any cycle.
REQ-020 Supported ops: 00000, 01000, 10100, 10010, 10001, 10000, 11000; with NUM_OPS_CHK = 1 any other op is still issued but rsp_err = 1 and rsp_data = 0.
REQ-021 Op 11000 (ECX decrement): ecx forwarded, mm1/mm2 zero; rsp_data = {32'd0, alu_res3[31:0]}.
REQ-022 Ops other than 11000 drive ecx = 0; op 10010 forwards sr2, all others drive sr2 = 0.
REQ-023 rsp_valid held with rsp_id/rsp_data/rsp_err stable until rsp_ready = 1 (no drop, no change while stalled).
REQ-024 Stall full: rsp_valid && !rsp_ready && s1_valid -> both ready outputs 0, S1 operands held stable.
REQ-025 Simultaneous S2 drain and new accept in same cycle permitted (full-rate pipe).
REQ-026 flush = 1: next edge clears s1_valid and rsp_valid; both ready outputs forced 0 that cycle; flush wins over any request.
REQ-027 last_grant unchanged by flush.

Reset
REQ-028 rst = 0 at edge: s1_valid = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0, alu3_op = 0, mm1 = mm2 = 0, sr2 = ecx = 0, last_grant = 1 (requester 0 wins first tie).
REQ-029 While rst = 0, req0_ready = req1_ready = 0; reset mid-operation discards all in-flight ops without a response.
REQ-030 First accept possible in the first cycle with rst = 1.

Verification
REQ-031 req0 op 00000, mm1 = 0x00000001_00000002, mm2 = 0x00000003_00000004, rsp_ready = 1 -> rsp_valid two edges later, rsp_id = 0, rsp_data = 0x00000004_00000006.
REQ-032 Both valid continuously for 4 cycles, FIXED_PRIO = 0 -> grant order 0,1,0,1; FIXED_PRIO = 1 -> 0,0,0,0.
REQ-033 req1 op 11000, ecx = 0x00000000 -> rsp_data = 0x00000000_FFFFFFFF, rsp_id = 1, rsp_err = 0.
REQ-034 rsp_ready = 0 for 3 cycles with 2 ops accepted -> third request sees ready = 0; rsp_data stable; on release two responses in order on consecutive cycles.
REQ-035 op 00111 with NUM_OPS_CHK = 1 -> rsp_err = 1, rsp_data = 0; flush with S1 and S2 full -> next cycle rsp_valid = 0, no response for either op.
REQ-036 rst = 0 asserted while rsp_valid = 1 -> next edge all outputs at REQ-028 values; after release, tie resolves to requester 0.

Source files
------------

// File: rtl/alu3_arb_if.sv
// alu3_arb_if: request, shared-ALU3 operand and response bundle for alu3_arb.
interface alu3_arb_if;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_op, req1_op, alu3_op;
  logic [63:0] req0_mm1, req0_mm2, req1_mm1, req1_mm2;
  logic [31:0] req0_sr2, req0_ecx, req1_sr2, req1_ecx;
  logic [63:0] mm1, mm2, alu_res3, rsp_data;
  logic [31:0] sr2, ecx;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, flush;
  modport slave (
    input  req0_valid, req0_op, req0_mm1, req0_mm2, req0_sr2, req0_ecx,
    input  req1_valid, req1_op, req1_mm1, req1_mm2, req1_sr2, req1_ecx,
    input  alu_res3, rsp_ready, flush,
    output req0_ready, req1_ready, alu3_op, mm1, mm2, sr2, ecx,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );
  modport master (
    output req0_valid, req0_op, req0_mm1, req0_mm2, req0_sr2, req0_ecx,
    output req1_valid, req1_op, req1_mm1, req1_mm2, req1_sr2, req1_ecx,
    output alu_res3, rsp_ready, flush,
    input  req0_ready, req1_ready, alu3_op, mm1, mm2, sr2, ecx,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu3_arb.sv
// alu3_arb: two-requester arbiter feeding a shared ALU3 through a two-stage operand/response pipe.
module alu3_arb #(
  parameter bit FIXED_PRIO  = 1'b0,
  parameter bit NUM_OPS_CHK = 1'b1
) (
  input logic       clk,
  input logic       rst,
  alu3_arb_if.slave bus
);
  localparam logic [4:0] OP_ECX = 5'b11000;
  localparam logic [4:0] OP_SR2 = 5'b10010;
  logic        s1_valid, s1_id, last_grant;
  logic        adv, accept, grant0, take, op_ok, err;
  logic [4:0]  op_in;
  logic [63:0] mm1_in, mm2_in;
  logic [31:0] sr2_in, ecx_in;
  // last_grant = 1 means requester 1 won last, so requester 0 takes the next tie
  always_comb begin
    adv            = !bus.rsp_valid || bus.rsp_ready;
    accept         = rst && !bus.flush && (!s1_valid || adv);
    grant0         = bus.req0_valid && (FIXED_PRIO || !bus.req1_valid || last_grant);
    bus.req0_ready = accept && grant0;
    bus.req1_ready = accept && bus.req1_valid && !grant0;
    take           = bus.req0_ready || bus.req1_ready;
    op_in          = grant0 ? bus.req0_op  : bus.req1_op;
    mm1_in         = grant0 ? bus.req0_mm1 : bus.req1_mm1;
    mm2_in         = grant0 ? bus.req0_mm2 : bus.req1_mm2;
    sr2_in         = grant0 ? bus.req0_sr2 : bus.req1_sr2;
    ecx_in         = grant0 ? bus.req0_ecx : bus.req1_ecx;
    op_ok          = bus.alu3_op inside {5'b00000, 5'b01000, 5'b10100, 5'b10010,
                                         5'b10001, 5'b10000, 5'b11000};
    err            = NUM_OPS_CHK && !op_ok;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid      <= 1'b0;
      s1_id         <= 1'b0;
      last_grant    <= 1'b1;
      bus.alu3_op   <= '0;
      bus.mm1       <= '0;
      bus.mm2       <= '0;
      bus.sr2       <= '0;
      bus.ecx       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      if (s1_valid && adv) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_id    <= s1_id;
        bus.rsp_err   <= err;
        bus.rsp_data  <= err ? '0 : (bus.alu3_op == OP_ECX) ? {32'd0, bus.alu_res3[31:0]} : bus.alu_res3;
      end else if (bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
      if (take) begin
        s1_valid    <= 1'b1;
        s1_id       <= !grant0;
        last_grant  <= !grant0;
        bus.alu3_op <= op_in;
        bus.mm1     <= (op_in == OP_ECX) ? '0 : mm1_in;
        bus.mm2     <= (op_in == OP_ECX) ? '0 : mm2_in;
        bus.sr2     <= (op_in == OP_SR2) ? sr2_in : '0;
        bus.ecx     <= (op_in == OP_ECX) ? ecx_in : '0;
      end else if (adv) begin
        s1_valid <= 1'b0;
      end
      if (bus.flush) begin
        s1_valid      <= 1'b0;
        bus.rsp_valid <= 1'b0;
      end
    end
  end
endmodule
